result_mailbox: RTL
===================

RESULT_MAILBOX -- requirements
Module: result_mailbox

Interface
REQ-001 Parameter ADDR_VALID, default 320, word address of the end-of-test valid flag register.
REQ-002 Parameter ADDR_DATA, default 321, word address of the result data register.
REQ-003 Parameter EXPIRED_CYCLES, default 600, RUN-state cycle budget before timeout.
REQ-004 Parameter BLINK_DIV, default 4, heartbeat LED advances every 2^BLINK_DIV cycles.
REQ-005 Port i_clk  input  1  single clock; all logic on rising edge.
REQ-006 Port i_rst  input  1  reset, synchronous, active-high.
REQ-007 Port i_we  input  1  CPU bus write strobe, one word per cycle.
REQ-008 Port i_re  input  1  CPU bus read strobe.
REQ-009 Port i_addr  input  10  CPU bus word address.
REQ-010 Port i_wdata  input  32  CPU bus write data.
REQ-011 Port o_rdata  output  32  CPU bus read data, registered.
REQ-012 Port o_sel  output  1  combinational address hit (i_addr == ADDR_VALID or ADDR_DATA) for bus mux.
REQ-013 Port i_ack  input  1  host acknowledge; consumes a result or timeout.
REQ-014 Port o_done  output  1  result valid, held until acknowledged.
REQ-015 Port o_result  output  32  latched result data.
REQ-016 Port o_timeout  output  1  cycle budget expired without valid flag.
REQ-017 Port o_leds  output  16  board LEDs.

Function
REQ-018 States RUN, DONE, TIMEOUT; encoding free.
REQ-019 RUN: cycle counter increments by 1 per cycle; o_leds = one-hot heartbeat rotating left, bit15 wraps to bit0, advancing every 2^BLINK_DIV cycles.
REQ-020 RUN, write to ADDR_DATA: data register <= i_wdata next edge; no state change.
REQ-021 RUN, write to ADDR_VALID with i_wdata[0]=1: next cycle state=DONE, o_done=1, o_result=data register, o_leds=data register[15:0].
REQ-022 RUN, write to ADDR_VALID with i_wdata[0]=0: no effect.
REQ-023 RUN, counter == EXPIRED_CYCLES-1 with no valid write that cycle: next cycle state=TIMEOUT, o_timeout=1, o_leds=16'hFFFF.
REQ-024 Valid write and expiry in the same cycle: DONE wins, o_timeout stays 0.
REQ-025 DONE/TIMEOUT: counter frozen; CPU writes to ADDR_DATA and ADDR_VALID ignored.
REQ-026 DONE or TIMEOUT with i_ack=1: next cycle state=RUN, counter=0, valid flag=0, o_done=0, o_timeout=0, heartbeat restarts at bit0; o_result and data register retained.
REQ-027 i_ack and a CPU write in the same cycle: ack takes effect, write dropped.
REQ-028 i_ack in RUN: ignored.
REQ-029 Read: i_re at cycle N, o_rdata valid at N+1: ADDR_VALID -> {31'b0, valid flag}; ADDR_DATA -> data register; other addresses -> 0; without i_re o_rdata holds.
REQ-030 Read and write to the same register in one cycle: o_rdata returns the pre-write value.
REQ-031 o_sel purely combinational from i_addr, independent of state.

Reset
REQ-032 i_rst=1 at a rising edge: state=RUN, counter=0, data register=0, valid flag=0, o_result=0, o_rdata=0, o_done=0, o_timeout=0, o_leds=16'h0001.
REQ-033 Reset overrides all other inputs in the same cycle, including mid-DONE and mid-TIMEOUT.

Verification
REQ-034 Write 0x30 to 321, then 1 to 320 -> next cycle o_done=1, o_result=0x30, o_leds=16'h0030, o_timeout=0.
REQ-035 No writes for 600 cycles after reset -> o_timeout=1 on cycle 600, o_leds=16'hFFFF; i_ack -> RUN, counter 0, o_timeout=0.
REQ-036 Valid write on cycle 599 (same cycle as expiry) -> o_done=1, o_timeout=0.
REQ-037 In DONE write 0x55 to 321 and 1 to 320, then read 321 -> o_rdata=0x30, o_result=0x30; i_ack -> o_done=0, o_result still 0x30.
REQ-038 Read 320 in DONE -> o_rdata=1 one cycle after i_re; read 322 -> o_rdata=0, o_sel=0.
REQ-039 Assert i_rst while in DONE with data 0x30 -> next cycle all outputs at REQ-032 values, heartbeat at bit1 after 16 further cycles.

Source files
------------

// File: rtl/result_mailbox.sv
// rtl/result_mailbox.sv - end-of-test result mailbox with cycle budget and heartbeat LEDs
//
// Purpose: collects a test result written by a CPU over a simple word bus.
// While running, it shows a rotating heartbeat on the LEDs and counts cycles.
// A write to the valid flag latches the result and shows it on the LEDs.
// If the cycle budget runs out first, it flags a timeout.
// The host acknowledge returns the mailbox to the running state.
//
// Ports:
//   i_clk      single clock, rising edge
//   i_rst      synchronous active-high reset
//   i_we       CPU write strobe
//   i_re       CPU read strobe
//   i_addr     CPU word address
//   i_wdata    CPU write data
//   o_rdata    CPU read data, registered, one cycle after i_re
//   o_sel      combinational address hit on either mailbox register
//   i_ack      host acknowledge of a result or timeout
//   o_done     result valid, held until acknowledged
//   o_result   latched result data
//   o_timeout  cycle budget expired without a valid flag
//   o_leds     heartbeat / result low half / all-on timeout pattern

module result_mailbox #(
    parameter int ADDR_VALID     = 320,
    parameter int ADDR_DATA      = 321,
    parameter int EXPIRED_CYCLES = 600,
    parameter int BLINK_DIV      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [9:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_sel,
    input  logic        i_ack,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic        o_timeout,
    output logic [15:0] o_leds
);

    // Wide enough to hold EXPIRED_CYCLES, the value left frozen when a valid
    // write lands on the last budget cycle.
    localparam int CW = $clog2(EXPIRED_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q;
    logic [BLINK_DIV-1:0]   pre_q;
    logic [15:0]            hb_q;
    logic [31:0]            data_q;
    logic                   valid_q;
    logic [31:0]            result_q;
    logic [31:0]            rdata_q;

    logic                   hit_valid;
    logic                   hit_data;
    logic                   load_data;
    logic                   set_valid;
    logic                   restart;

    assign hit_valid = (i_addr == 10'(ADDR_VALID));
    assign hit_data  = (i_addr == 10'(ADDR_DATA));
    assign o_sel     = hit_valid | hit_data;

    always_comb begin
        state_d   = state_q;
        load_data = 1'b0;
        set_valid = 1'b0;
        restart   = 1'b0;
        case (state_q)
            ST_RUN: begin
                load_data = i_we & hit_data;
                // A valid write takes priority over expiry in the same cycle.
                if (i_we && hit_valid && i_wdata[0]) begin
                    set_valid = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CW'(EXPIRED_CYCLES - 1)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                // CPU writes are ignored here, so a write alongside ack is dropped.
                if (i_ack) begin
                    restart = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            pre_q    <= '0;
            hb_q     <= 16'h0001;
            data_q   <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;

            // Reads see the register contents before any write in this cycle.
            if (i_re) begin
                if (hit_valid) begin
                    rdata_q <= {31'b0, valid_q};
                end else if (hit_data) begin
                    rdata_q <= data_q;
                end else begin
                    rdata_q <= '0;
                end
            end

            if (state_q == ST_RUN) begin
                cnt_q <= cnt_q + 1'b1;
                pre_q <= pre_q + 1'b1;
                if (&pre_q) begin
                    hb_q <= {hb_q[14:0], hb_q[15]};
                end
                if (load_data) begin
                    data_q <= i_wdata;
                end
                if (set_valid) begin
                    valid_q  <= 1'b1;
                    result_q <= data_q;
                end
            end else if (restart) begin
                cnt_q   <= '0;
                pre_q   <= '0;
                hb_q    <= 16'h0001;
                valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        o_leds = hb_q;
        case (state_q)
            ST_DONE:    o_leds = result_q[15:0];
            ST_TIMEOUT: o_leds = 16'hFFFF;
            default:    o_leds = hb_q;
        endcase
    end

    assign o_done    = (state_q == ST_DONE);
    assign o_timeout = (state_q == ST_TIMEOUT);
    assign o_result  = result_q;
    assign o_rdata   = rdata_q;

endmodule
